// File: rtl/serializer_pkg.sv
// Shared types and defaults for the bit stream serializer.
// Optional parity bit per word: SERIALIZER_PARITY_EN.
package serializer_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    // Even parity; narrower words are zero-extended by the caller.
    function automatic logic even_parity(input logic [63:0] w);
        return ^w;
    endfunction

endpackage

// File: rtl/serializer_fifo.sv
// Word buffer in front of the serializer shifter.
// Power-of-two depth, pointers wrap naturally.
import serializer_pkg::*;

module serializer_fifo #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count < CNT_W'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care after reset.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial feeder, MSB first, with framing strobes.
// Optional parity bit per word: SERIALIZER_PARITY_EN.
import serializer_pkg::*;

module bit_stream_serializer #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             hold,
    output logic             i,
    output logic             bit_valid,
    output logic             word_start,
    output logic             busy,
    output logic [CNT_W-1:0] fifo_count
);

    localparam int IDX_W = $clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] rdata;
    logic [WIDTH-1:0] sreg;
    logic [IDX_W-1:0] bit_idx;
    logic             last;
    logic             has_word;
    logic             at_end;
    logic             load;
    logic             push;

    assign in_ready = fifo_count < CNT_W'(DEPTH);
    assign push     = in_valid && in_ready;
    assign has_word = fifo_count != '0;
    assign busy     = (state != IDLE) || has_word;

`ifdef SERIALIZER_PARITY_EN
    assign at_end = (state == IDLE) || (state == PARITY);
`else
    assign at_end = (state == IDLE) || ((state == SHIFT) && last);
`endif

    assign load = !hold && has_word && at_end;

    serializer_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (load),
        .wdata (in_data),
        .rdata (rdata),
        .count (fifo_count)
    );

    // FSM and shifter: load, shift MSB..LSB, optional parity, chain.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            sreg       <= '0;
            bit_idx    <= '0;
            last       <= 1'b0;
            i          <= 1'b0;
            bit_valid  <= 1'b0;
            word_start <= 1'b0;
        end else begin
            bit_valid  <= 1'b0;
            word_start <= 1'b0;
            if (hold) begin
                state <= state;
            end else if (load) begin
                sreg       <= rdata;
                i          <= rdata[WIDTH-1];
                bit_valid  <= 1'b1;
                word_start <= 1'b1;
                bit_idx    <= IDX_W'(WIDTH - 2);
                last       <= 1'b0;
                state      <= SHIFT;
            end else if ((state == SHIFT) && !last) begin
                i         <= sreg[bit_idx];
                bit_valid <= 1'b1;
                bit_idx   <= bit_idx - IDX_W'(1);
                last      <= (bit_idx == '0);
`ifdef SERIALIZER_PARITY_EN
            end else if (state == SHIFT) begin
                i         <= even_parity(64'(sreg));
                bit_valid <= 1'b1;
                last      <= 1'b0;
                state     <= PARITY;
`endif
            end else begin
                i     <= 1'b0;
                last  <= 1'b0;
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Randomized and directed bench for bit_stream_serializer
// against a bit-stream level scoreboard model.
module tb_bit_stream_serializer;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CW = 3;
`ifdef SERIALIZER_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          hold = 1'b0;
    logic          i;
    logic          bit_valid;
    logic          word_start;
    logic          busy;
    logic [CW-1:0] fifo_count;

    bit_stream_serializer #(.WIDTH(W), .DEPTH(D)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .hold       (hold),
        .i          (i),
        .bit_valid  (bit_valid),
        .word_start (word_start),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // model state
    logic [W-1:0] q[$];
    logic [W-1:0] cur;
    int           pos = 0;
    bit           inword = 1'b0;
    logic         prev_i = 1'b0;
    logic [31:0]  stream = '0;
    int           nbits = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_bits(input logic [W-1:0] w);
`ifdef SERIALIZER_PARITY_EN
        return {23'd0, w, ^w};
`else
        return {24'd0, w};
`endif
    endfunction

    task automatic model_reset();
        q.delete();
        pos    = 0;
        inword = 1'b0;
        prev_i = 1'b0;
    endtask

    task automatic step(input bit v, input logic [W-1:0] d, input bit h,
                        output bit acc);
        int   cnt_before;
        logic ei, ebv, ews;
        in_valid = v;
        in_data  = d;
        hold     = h;
        #1;
        check("in_ready", 32'(in_ready), 32'(q.size() < D));
        acc        = v && (q.size() < D);
        cnt_before = q.size();
        @(posedge clock);
        #1;
        if (h) begin
            ebv = 0; ews = 0; ei = prev_i;
        end else if (inword && pos < NB) begin
            ei  = (pos < W) ? cur[W-1-pos] : ^cur;
            ebv = 1; ews = 0;
            pos++;
        end else if (cnt_before > 0) begin
            cur = q.pop_front();
            ei  = cur[W-1];
            ebv = 1; ews = 1;
            pos = 1; inword = 1'b1;
        end else begin
            ebv = 0; ews = 0; ei = 0;
            inword = 1'b0;
        end
        if (acc) q.push_back(d);
        check("bit_valid", 32'(bit_valid), 32'(ebv));
        check("word_start", 32'(word_start), 32'(ews));
        check("i", 32'(i), 32'(ei));
        check("fifo_count", 32'(fifo_count), 32'(q.size()));
        check("busy", 32'(busy), 32'(inword || q.size() != 0));
        if (bit_valid) begin
            stream = {stream[30:0], i};
            nbits++;
        end
        prev_i = ei;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, a);
    endtask

    task automatic drain();
        bit a;
        int guard = 0;
        while ((q.size() != 0 || inword) && guard < 300) begin
            step(1'b0, '0, 1'b0, a);
            guard++;
        end
        check("drain_timeout", 32'(guard < 300), 32'd1);
        idle(2);
    endtask

    initial begin
        bit           a;
        int           k;
        logic [W-1:0] words[6];
        logic [31:0]  e2;

        // reset values
        #2;
        check("rst_i", 32'(i), 32'd0);
        check("rst_bv", 32'(bit_valid), 32'd0);
        check("rst_ws", 32'(word_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_count", 32'(fifo_count), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // single word A5, then 01
        stream = 0; nbits = 0;
        step(1'b1, 8'hA5, 1'b0, a);
        idle(NB + 2);
        check("t1_bits", 32'(nbits), 32'(NB));
        check("t1_stream", stream & ((32'd1 << NB) - 1), exp_bits(8'hA5));
        check("t1_idle_busy", 32'(busy), 32'd0);
        stream = 0; nbits = 0;
        step(1'b1, 8'h01, 1'b0, a);
        idle(NB + 2);
        check("t6_stream", stream & ((32'd1 << NB) - 1), exp_bits(8'h01));

        // back to back FF, 00
        stream = 0; nbits = 0;
        step(1'b1, 8'hFF, 1'b0, a);
        step(1'b1, 8'h00, 1'b0, a);
        idle(2 * NB + 2);
        e2 = (exp_bits(8'hFF) << NB) | exp_bits(8'h00);
        check("t2_bits", 32'(nbits), 32'(2 * NB));
        check("t2_stream", stream & ((32'd1 << (2 * NB)) - 1), e2);

        // overfill under hold
        words = '{8'h11, 8'h82, 8'h3C, 8'hE7, 8'h5A, 8'h96};
        k = 0;
        for (int c = 0; c < 6; c++) begin
            step(1'b1, words[k], 1'b1, a);
            if (a) k++;
        end
        check("t3_count", 32'(fifo_count), 32'd4);
        check("t3_ready", 32'(in_ready), 32'd0);
        check("t3_accepted", 32'(k), 32'd4);
        while (k < 6) begin
            step(1'b1, words[k], 1'b0, a);
            if (a) k++;
        end
        drain();

        // hold mid-word on C3
        nbits = 0;
        step(1'b1, 8'hC3, 1'b0, a);
        idle(2);
        for (int c = 0; c < 3; c++) step(1'b0, '0, 1'b1, a);
        idle(NB);
        check("t4_bits", 32'(nbits), 32'(NB));

        // async reset mid-word with queued words
        step(1'b1, 8'h6D, 1'b0, a);
        step(1'b1, 8'hB2, 1'b0, a);
        step(1'b1, 8'h47, 1'b0, a);
        idle(2);
        #3;
        reset = 1'b0;
        #1;
        check("t5_i", 32'(i), 32'd0);
        check("t5_bv", 32'(bit_valid), 32'd0);
        check("t5_count", 32'(fifo_count), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        model_reset();
        #2;
        reset = 1'b1;
        idle(4);

        // random traffic
        for (int c = 0; c < 600; c++) begin
            step(($urandom % 3) != 0, W'($urandom), ($urandom % 5) == 0, a);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
